// File: rtl/mux_arb_n_if.sv
// mux_arb_n_if: channel-side and consumer-side handshake bundle for mux_arb_n
interface mux_arb_n_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      sel_en;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;
  modport slave (
    input  in_data, in_valid, sel_en, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
  modport master (
    output in_data, in_valid, sel_en, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel registered mux with select/arbitration; MUX_ARB_RR_EN selects round-robin over fixed priority
module mux_arb_n #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
) (
  input logic         clk,
  input logic         rst_n,
  mux_arb_n_if.slave  bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  logic [WIDTH-1:0]    out_data_q, out_data_d, sel_data;
  logic [SEL_W-1:0]    out_chan_q, out_chan_d, sel_chan;
  logic                out_valid_q, out_valid_d;
  logic [CHANNELS-1:0] grant;
  logic                load, xfer, found;
`ifdef MUX_ARB_RR_EN
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  int                  idx;
`endif
  assign load = ~out_valid_q | bus.out_ready;
  always_comb begin
    grant = '0;
    found = 1'b0;
`ifdef MUX_ARB_RR_EN
    idx = 0;
`endif
    if (bus.sel_en) begin
      for (int i = 0; i < CHANNELS; i++)
        grant[i] = (bus.sel == SEL_W'(i)) & bus.in_valid[i];
    end else begin
`ifdef MUX_ARB_RR_EN
      for (int k = 0; k < CHANNELS; k++) begin
        idx = (int'(ptr_q) + k) % CHANNELS;
        if (!found && bus.in_valid[idx]) begin
          grant[idx] = 1'b1;
          found = 1'b1;
        end
      end
`else
      for (int i = 0; i < CHANNELS; i++) begin
        if (!found && bus.in_valid[i]) begin
          grant[i] = 1'b1;
          found = 1'b1;
        end
      end
`endif
    end
  end
  always_comb begin
    sel_data = '0;
    sel_chan = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) begin
        sel_data = bus.in_data[i*WIDTH +: WIDTH];
        sel_chan = SEL_W'(i);
      end
    end
  end
  always_comb begin
    bus.in_ready = rst_n ? (grant & {CHANNELS{load}}) : '0;
    xfer        = |bus.in_ready;
    out_valid_d = xfer | (out_valid_q & ~bus.out_ready);
    out_data_d  = xfer ? sel_data : out_data_q;
    out_chan_d  = xfer ? sel_chan : out_chan_q;
`ifdef MUX_ARB_RR_EN
    ptr_d = !xfer ? ptr_q : (sel_chan == SEL_W'(CHANNELS-1)) ? '0 : sel_chan + SEL_W'(1);
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
`ifdef MUX_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
`ifdef MUX_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshake. It generalises the fixed 4:1 gate-level mux to any channel count and width. Channel choice is explicit (a select port) or arbitrated among requesting channels. It sits between multiple datapath producers (e.g. PC sources, writeback sources, memory requesters) and a single consumer, and provides a one-entry output register that gives one cycle of latency at full throughput.

## Interface
- WIDTH, 32, data width per channel (>=1)
- CHANNELS, 4, number of input channels (>=2)
- SEL_W, $clog2(CHANNELS), derived localparam, select/channel-index width
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk edge
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i at [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel request
- in_ready  output  CHANNELS  per-channel accept (combinational, one-hot or zero)
- sel_en  input  1  1 = explicit select mode, 0 = arbitration mode
- sel  input  SEL_W  channel index used when sel_en=1
- out_data  output  WIDTH  registered selected data
- out_chan  output  SEL_W  registered index of the channel that produced out_data
- out_valid  output  1  output register holds data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- load = !out_valid | out_ready. The output register takes new data only when load=1.
- Grant (combinational, at most one bit set):
  - sel_en=1: grant channel sel iff in_valid[sel]=1 and sel<CHANNELS. There is no fallback to other channels. sel>=CHANNELS grants nothing.
  - sel_en=0: grant one valid channel per the arbitration policy (see Configuration). No valid channel means no grant.
- in_ready[i] = grant[i] & load. Transfer on channel i occurs when in_valid[i] & in_ready[i].
- On transfer: out_data <= in_data[i], out_chan <= i, out_valid <= 1.
- On out_valid & out_ready with no new transfer: out_valid <= 0. out_data and out_chan hold their last values.
- Simultaneous drain and accept in the same cycle: out_valid stays 1 and the register is replaced with the new data. No bubble.
- Priority pointer ptr (SEL_W bits) is used in round-robin builds only. On any transfer, including one made in explicit mode, ptr <= (i+1) mod CHANNELS. Wrap: after a grant to channel CHANNELS-1, ptr returns to 0. ptr holds when there is no transfer.
- Inputs need not stay stable while unaccepted. The block never buffers more than one entry.

## Timing
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_chan=0, ptr=0. While rst_n=0, in_ready is forced to all-zero.
- Reset mid-operation: the pending output entry is discarded. The first accept can occur in the first cycle with rst_n=1.
- Latency: data accepted at edge k appears on out_data with out_valid=1 after edge k. That is 1 cycle.
- Throughput: 1 transfer per cycle while out_ready=1.
- Stall: out_valid=1 & out_ready=0 forces in_ready=0. out_data and out_chan stay stable until drained.
- in_ready depends combinationally on in_valid, sel_en, sel, out_ready and the current state. It has no dependency on its own value.

## Configuration
- MUX_ARB_RR_EN defined: arbitration mode is round-robin. The granted channel is the first valid channel scanning ptr, ptr+1, … with wrap, so every continuously requesting channel is served within CHANNELS transfers.
- MUX_ARB_RR_EN undefined: arbitration mode is fixed priority, with the lowest valid index winning. ptr and its logic are not built. Explicit mode is identical in both builds.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_chan=0. After release with sel_en=0 -> channel 0 is accepted on the first edge.
- Explicit select: CHANNELS=4, WIDTH=32, sel_en=1, sel=2, in_valid=4'b1111, in_data[2]=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_data=32'hDEADBEEF, out_chan=2. Then sel=3 with in_valid[3]=0 -> in_ready=0, and out_valid drops after one cycle.
- Round-robin (MUX_ARB_RR_EN): sel_en=0, in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0, one per cycle. With in_valid=4'b1010 -> 1,3,1,3.
- Fixed priority (macro undefined): in_valid=4'b1110 held -> out_chan=1 on every cycle.
- Backpressure: out_ready=0 for 4 cycles after one accept -> out_valid=1, out_data stable, in_ready=0. Raise out_ready with a request pending -> drain and new accept in the same cycle, and out_valid stays 1.
- Mid-stream reset: assert rst_n=0 while out_valid=1 -> out_valid=0 next edge. In a round-robin build ptr returns to 0, so the first grant after release goes to channel 0.
